// File: rtl/swnet_multi_stage_if.sv
// Streaming bus for the switch stage: framed input words in, switched words out.
// The master drives words in and watches the switched stream; the slave is the switch stage.
interface swnet_multi_stage_if #(
   parameter int WIDTH = 32,
   parameter int NSW   = 2,
   parameter int PW    = 1
);
   logic                      in_valid;
   logic                      in_start;
   logic [1:0]                mode;
   logic [2*NSW*WIDTH-1:0]    in_data;
   logic                      out_valid;
   logic                      out_start;
   logic [PW-1:0]             out_phase;
   logic [2*NSW*WIDTH-1:0]    out_data;

   modport master (
      output in_valid, in_start, mode, in_data,
      input  out_valid, out_start, out_phase, out_data
   );

   modport slave (
      input  in_valid, in_start, mode, in_data,
      output out_valid, out_start, out_phase, out_data
   );
endinterface

// File: rtl/swnet_multi_stage.sv
// NSW independent 2x2 lane switches driven by a phase schedule and a run-time mode,
// followed by a two-register pipeline that carries valid/start/phase with each word.
module swnet_multi_stage #(
   parameter int                    WIDTH      = 32,
   parameter int                    NSW        = 2,
   parameter int                    PERIOD     = 2,
   parameter logic [PERIOD*NSW-1:0] CTRL_TABLE = '0,
   parameter int                    PW         = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input logic                 clk,
   input logic                 rst_n,
   swnet_multi_stage_if.slave  bus
);

   localparam int LW = 2*NSW*WIDTH;

   logic [PW-1:0]  phase_q, phase_d;
   logic [PW-1:0]  wordPhase;
   logic [NSW-1:0] swSched, swEff;
   logic [LW-1:0]  muxData;

   logic           s1Valid_q, s1Start_q;
   logic [PW-1:0]  s1Phase_q;
   logic [LW-1:0]  s1Data_q;

   logic           outValid_q, outStart_q;
   logic [PW-1:0]  outPhase_q;
   logic [LW-1:0]  outData_q;

   // A start word always restarts the schedule, even when it coincides with a wrap.
   always_comb begin
      wordPhase = bus.in_start ? '0 : phase_q;
      swSched   = CTRL_TABLE[int'(wordPhase)*NSW +: NSW];
      case (bus.mode)
         2'b01:   swEff = '0;
         2'b10:   swEff = '1;
         2'b11:   swEff = ~swSched;
         default: swEff = swSched;
      endcase
      phase_d = phase_q;
      if (bus.in_valid) begin
         phase_d = (wordPhase == PW'(PERIOD-1)) ? '0 : wordPhase + PW'(1);
      end
   end

   always_comb begin
      muxData = bus.in_data;
      for (int s = 0; s < NSW; s++) begin
         if (swEff[s]) begin
            muxData[(2*s)*WIDTH   +: WIDTH] = bus.in_data[(2*s+1)*WIDTH +: WIDTH];
            muxData[(2*s+1)*WIDTH +: WIDTH] = bus.in_data[(2*s)*WIDTH   +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Valid bits shift every cycle so bubbles flow through; payload holds during gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1Start_q  <= 1'b0;
         s1Phase_q  <= '0;
         s1Data_q   <= '0;
         outValid_q <= 1'b0;
         outStart_q <= 1'b0;
         outPhase_q <= '0;
         outData_q  <= '0;
      end else begin
         s1Valid_q  <= bus.in_valid;
         outValid_q <= s1Valid_q;
         if (bus.in_valid) begin
            s1Start_q <= bus.in_start;
            s1Phase_q <= wordPhase;
            s1Data_q  <= muxData;
         end
         if (s1Valid_q) begin
            outStart_q <= s1Start_q;
            outPhase_q <= s1Phase_q;
            outData_q  <= s1Data_q;
         end
      end
   end

   assign bus.out_valid = outValid_q;
   assign bus.out_start = outStart_q;
   assign bus.out_phase = outPhase_q;
   assign bus.out_data  = outData_q;

endmodule

// File: tb/tb_swnet_multi_stage.sv
// Scoreboard bench: DUT A uses the 4'b1001 two-phase schedule, DUT B is PERIOD=1 all-swap.
// Both see identical stimulus; expected words are queued at drive time and popped on out_valid.
module tb_swnet_multi_stage;

   logic clk;
   logic rst_n;
   int   cyc;
   int   totalCnt;
   int   badCnt;

   typedef struct {
      logic [31:0] data;
      logic        start;
      logic        phase;
      int          cyc;
   } exp_t;

   exp_t        sbA[$];
   exp_t        sbB[$];
   logic [31:0] lastA, lastB;
   logic        phaseA;
   logic [3:0]  tblA;

   swnet_multi_stage_if #(.WIDTH(8), .NSW(2), .PW(1)) busA();
   swnet_multi_stage_if #(.WIDTH(8), .NSW(2), .PW(1)) busB();

   swnet_multi_stage #(.WIDTH(8), .NSW(2), .PERIOD(2), .CTRL_TABLE(4'b1001)) dutA (
      .clk(clk), .rst_n(rst_n), .bus(busA)
   );

   swnet_multi_stage #(.WIDTH(8), .NSW(2), .PERIOD(1), .CTRL_TABLE(2'b11)) dutB (
      .clk(clk), .rst_n(rst_n), .bus(busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCnt++;
      if (observed !== expected) begin
         badCnt++;
         $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] modelSwitch(input logic [31:0] d, input logic [1:0] sw);
      logic [31:0] r;
      r = d;
      for (int s = 0; s < 2; s++) begin
         if (sw[s]) begin
            r[16*s +: 8]   = d[16*s+8 +: 8];
            r[16*s+8 +: 8] = d[16*s +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [1:0] applyMode(input logic [1:0] sched, input logic [1:0] m);
      case (m)
         2'b01:   return 2'b00;
         2'b10:   return 2'b11;
         2'b11:   return ~sched;
         default: return sched;
      endcase
   endfunction

   task automatic applyStimulus(input logic v, input logic s, input logic [1:0] m, input logic [31:0] d);
      exp_t e;
      logic p;
      busA.in_valid = v; busA.in_start = s; busA.mode = m; busA.in_data = d;
      busB.in_valid = v; busB.in_start = s; busB.mode = m; busB.in_data = d;
      if (v) begin
         p       = s ? 1'b0 : phaseA;
         e.data  = modelSwitch(d, applyMode(tblA[2*p +: 2], m));
         e.start = s;
         e.phase = p;
         e.cyc   = cyc + 2;
         sbA.push_back(e);
         phaseA  = ~p;
         e.data  = modelSwitch(d, applyMode(2'b11, m));
         e.phase = 1'b0;
         sbB.push_back(e);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic applyReset();
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rstA valid", {31'b0, busA.out_valid}, 32'h0);
      checkOutput("rstA data", busA.out_data, 32'h0);
      checkOutput("rstB valid", {31'b0, busB.out_valid}, 32'h0);
      checkOutput("rstB data", busB.out_data, 32'h0);
      checkOutput("rstA phase", {31'b0, busA.out_phase}, 32'h0);
      sbA.delete();
      sbB.delete();
      lastA  = '0;
      lastB  = '0;
      phaseA = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (busA.out_valid) begin
            if (sbA.size() == 0) begin
               checkOutput("A unexpected word", sbA.size(), 1);
            end else begin
               e = sbA.pop_front();
               checkOutput("A data", busA.out_data, e.data);
               checkOutput("A start", {31'b0, busA.out_start}, {31'b0, e.start});
               checkOutput("A phase", {31'b0, busA.out_phase}, {31'b0, e.phase});
               checkOutput("A latency", cyc, e.cyc);
               lastA = e.data;
            end
         end else begin
            checkOutput("A hold", busA.out_data, lastA);
         end
         if (busB.out_valid) begin
            if (sbB.size() == 0) begin
               checkOutput("B unexpected word", sbB.size(), 1);
            end else begin
               e = sbB.pop_front();
               checkOutput("B data", busB.out_data, e.data);
               checkOutput("B start", {31'b0, busB.out_start}, {31'b0, e.start});
               checkOutput("B phase", {31'b0, busB.out_phase}, 32'h0);
               checkOutput("B latency", cyc, e.cyc);
               lastB = e.data;
            end
         end else begin
            checkOutput("B hold", busB.out_data, lastB);
         end
      end
   end

   initial begin
      totalCnt = 0;
      badCnt   = 0;
      cyc      = 0;
      tblA     = 4'b1001;
      phaseA   = 1'b0;
      lastA    = '0;
      lastB    = '0;
      rst_n    = 1'b1;
      busA.in_valid = 1'b0; busA.in_start = 1'b0; busA.mode = 2'b00; busA.in_data = '0;
      busB.in_valid = 1'b0; busB.in_start = 1'b0; busB.mode = 2'b00; busB.in_data = '0;
      @(posedge clk);
      #2;
      applyReset();

      $display("[TB] schedule and framing");
      applyStimulus(1, 1, 2'b00, 32'h44332211);
      applyStimulus(1, 0, 2'b00, 32'h44332211);
      applyStimulus(0, 0, 2'b00, 32'h0);

      $display("[TB] bubbles");
      applyStimulus(1, 1, 2'b00, 32'hA1B2C3D4);
      applyStimulus(0, 0, 2'b00, 32'h0);
      applyStimulus(0, 0, 2'b00, 32'h0);
      applyStimulus(1, 0, 2'b00, 32'h01020304);
      applyStimulus(0, 0, 2'b00, 32'h0);
      applyStimulus(0, 0, 2'b00, 32'h0);

      $display("[TB] modes");
      applyStimulus(1, 1, 2'b01, 32'h44332211);
      applyStimulus(1, 1, 2'b10, 32'h44332211);
      applyStimulus(1, 1, 2'b11, 32'h44332211);
      applyStimulus(1, 0, 2'b11, 32'h44332211);

      $display("[TB] restart at phase 1");
      applyStimulus(1, 1, 2'b00, 32'h55667788);
      applyStimulus(1, 1, 2'b00, 32'h99AABBCC);
      applyStimulus(1, 0, 2'b00, 32'hDDEEFF00);
      applyStimulus(0, 0, 2'b00, 32'h0);
      applyStimulus(0, 0, 2'b00, 32'h0);
      applyStimulus(0, 0, 2'b00, 32'h0);

      $display("[TB] reset mid-stream");
      applyStimulus(1, 0, 2'b00, 32'h12345678);
      applyStimulus(1, 0, 2'b00, 32'h9ABCDEF0);
      applyReset();
      applyStimulus(1, 0, 2'b00, 32'h44332211);
      applyStimulus(1, 0, 2'b00, 32'h44332211);

      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                       2'($urandom_range(0, 3)), $urandom);
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b00, 32'h0);

      checkOutput("A drain", sbA.size(), 0);
      checkOutput("B drain", sbB.size(), 0);
      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
